uart_tx_ctrl: RTL and testbench

Frame sequencer for the UART transmitter's bit-serial shift register, which is built from shift/write-gated flip-flops.
- Accepts a byte request and loads the shift register.
- Sequences start, data, optional parity and stop bits at the baud rate.
- Drives the serial line and reports busy/done to the host logic.
- Sits between the host request interface and the shift-register datapath.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_cnt.sv | 28 ++
 rtl/uart_tx_ctrl.sv | 145 ++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the UART transmit/receive blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int CLKS_PER_BIT_DEF = 868;
    localparam int DATA_BITS_DEF    = 8;

    // Width of a baud counter that must also span the full stop period.
    function automatic int baud_cnt_width(input int clks_per_bit, input int stop_bits);
        return $clog2(clks_per_bit * stop_bits);
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud-period counter: counts 0..last and wraps, raising bit_end on the
// terminal count. The clear input holds it at zero (e.g. while idle).
module uart_baud_cnt #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] last,
    output logic             bit_end
);

    logic [WIDTH-1:0] count;

    assign bit_end = (count == last);

    // Free-running up count with wrap at the terminal value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || bit_end) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer. Drives the load/shift/step controls of an
// external LSB-first shift register and serialises start, data, optional
// parity and stop bits onto tx_out.
//
// Data-bit timing: sr_step is issued at the start of each data bit except
// the last, so the register already presents the next bit when the current
// bit period ends; tx_out samples sr_serial_in on each bit boundary, which
// keeps every bit on the line exactly CLKS_PER_BIT cycles long.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = DATA_BITS_DEF,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 sr_serial_in,
    output logic                 sr_write,
    output logic                 sr_shift,
    output logic                 sr_step,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CNT_W = baud_cnt_width(CLKS_PER_BIT, STOP_BITS);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] PRE_LAST  = BIT_W'(DATA_BITS - 2);

    tx_state_t        state;
    logic [BIT_W-1:0] bit_cnt;
    logic             parity_bit;
    logic             bit_end;
    logic             baud_clear;
    logic [CNT_W-1:0] baud_last;

    // The stop phase is timed as one long period so the counter wraps once.
    assign baud_clear = (state == IDLE);
    assign baud_last  = (state == STOP) ? STOP_LAST : BIT_LAST;

    uart_baud_cnt #(
        .WIDTH(CNT_W)
    ) u_baud_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (baud_clear),
        .last   (baud_last),
        .bit_end(bit_end)
    );

    // Frame FSM with bit counter and registered line/strobe outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            parity_bit <= 1'b0;
            tx_out     <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            sr_write   <= 1'b0;
            sr_shift   <= 1'b0;
            sr_step    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; these defaults are
            // overridden later in the same block, which is what makes the
            // strobes single-cycle pulses without separate clear logic.
            sr_write <= 1'b0;
            sr_step  <= 1'b0;
            tx_done  <= 1'b0;

            case (state)
                IDLE: begin
                    tx_out <= 1'b1;
                    if (tx_start) begin
                        parity_bit <= (^tx_data) ^ 1'(PARITY_ODD);
                        state      <= START;
                        tx_out     <= 1'b0;
                        tx_busy    <= 1'b1;
                        sr_write   <= 1'b1;
                    end
                end

                START: begin
                    // Hold the register out of clear once the load strobe is done.
                    sr_shift <= 1'b1;
                    if (bit_end) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        tx_out  <= sr_serial_in;
                        sr_step <= 1'b1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == LAST_BIT) begin
                            sr_shift <= 1'b0;
                            if (PARITY_EN != 0) begin
                                state  <= PARITY;
                                tx_out <= parity_bit;
                            end else begin
                                state  <= STOP;
                                tx_out <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_out  <= sr_serial_in;
                            sr_step <= (bit_cnt != PRE_LAST);
                        end
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        state  <= STOP;
                        tx_out <= 1'b1;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        state   <= IDLE;
                        tx_out  <= 1'b1;
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl. Four instances cover the parameter
// variants (plain 8N1, even parity, odd parity, 7 data bits with 2 stops),
// each with a small LSB-first shift-register model on its sr_* controls.
module tb_uart_tx_ctrl;

    localparam int CLKS = 4;

    logic       clk;
    logic       reset;
    logic [3:0] start_v;
    logic [7:0] data_v [4];
    logic [3:0] ser_v;
    logic [3:0] wr_v, shift_v, step_v, tx_out_v, busy_v, done_v;

    logic [7:0] sr_m [4];
    int         step_cnt [4];
    int         wr_cnt [4];
    int         done_cnt [4];
    logic       clr_cnt;

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gen_dut
        localparam int DB = (g == 3) ? 7 : 8;
        uart_tx_ctrl #(
            .CLKS_PER_BIT(CLKS),
            .DATA_BITS   (DB),
            .PARITY_EN   ((g == 1 || g == 2) ? 1 : 0),
            .PARITY_ODD  ((g == 2) ? 1 : 0),
            .STOP_BITS   ((g == 3) ? 2 : 1)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .tx_start    (start_v[g]),
            .tx_data     (data_v[g][DB-1:0]),
            .sr_serial_in(ser_v[g]),
            .sr_write    (wr_v[g]),
            .sr_shift    (shift_v[g]),
            .sr_step     (step_v[g]),
            .tx_out      (tx_out_v[g]),
            .tx_busy     (busy_v[g]),
            .tx_done     (done_v[g])
        );
        assign ser_v[g] = sr_m[g][0];
    end

    // Shift-register model plus strobe counters for every instance.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_v[i[1:0]]) begin
                sr_m[i[1:0]] <= data_v[i[1:0]];
            end else if (step_v[i[1:0]]) begin
                sr_m[i[1:0]] <= sr_m[i[1:0]] >> 1;
            end
            if (clr_cnt) begin
                step_cnt[i[1:0]] <= 0;
                wr_cnt[i[1:0]]   <= 0;
                done_cnt[i[1:0]] <= 0;
            end else begin
                step_cnt[i[1:0]] <= step_cnt[i[1:0]] + (step_v[i[1:0]] ? 1 : 0);
                wr_cnt[i[1:0]]   <= wr_cnt[i[1:0]] + (wr_v[i[1:0]] ? 1 : 0);
                done_cnt[i[1:0]] <= done_cnt[i[1:0]] + (done_v[i[1:0]] ? 1 : 0);
            end
        end
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Called at a negedge; leaves the bench at the negedge after the accept edge.
    task automatic start_frame(input int idx, input logic [7:0] d);
        logic [1:0] k;
        k          = idx[1:0];
        clr_cnt    = 1'b1;
        data_v[k]  = d;
        start_v[k] = 1'b1;
        @(negedge clk);
        clr_cnt    = 1'b0;
        start_v[k] = 1'b0;
    endtask

    // Walks one frame cycle by cycle from the negedge after the accept edge
    // (c=0) to the done cycle (c=len). Optionally pokes tx_start/0xFF mid
    // frame, and optionally requests the next frame in the done cycle.
    task automatic watch_frame(input int idx, input logic [7:0] data, input int nbits,
                               input bit par_en, input bit par_bit, input int stops,
                               input int poke_at, input bit chain, input logic [7:0] next_data);
        logic [1:0] k;
        logic [7:0] tmp;
        logic       exp_line;
        int         len;
        int         bitpos;
        k   = idx[1:0];
        len = (1 + nbits + (par_en ? 1 : 0) + stops) * CLKS;
        for (int c = 0; c <= len; c++) begin
            if (c < len) begin
                bitpos = c / CLKS;
                if (bitpos == 0) begin
                    exp_line = 1'b0;
                end else if (bitpos <= nbits) begin
                    tmp      = data >> (bitpos - 1);
                    exp_line = tmp[0];
                end else if (par_en && bitpos == nbits + 1) begin
                    exp_line = par_bit;
                end else begin
                    exp_line = 1'b1;
                end
                check("line", tx_out_v[k], exp_line);
                check("busy", busy_v[k], 1'b1);
                check("done_early", done_v[k], 1'b0);
                check("write_only_first", wr_v[k], c == 0);
                check("write_step_excl", wr_v[k] & step_v[k], 1'b0);
                check("write_or_shift", wr_v[k] | shift_v[k], c < (1 + nbits) * CLKS);
            end else begin
                check("done_pulse", done_v[k], 1'b1);
                check("done_busy", busy_v[k], 1'b0);
                check("done_line", tx_out_v[k], 1'b1);
            end
            if (c == poke_at) begin
                start_v[k] = 1'b1;
                data_v[k]  = 8'hFF;
            end else if (c == poke_at + 1) begin
                start_v[k] = 1'b0;
            end
            if (c == len && chain) begin
                start_v[k] = 1'b1;
                data_v[k]  = next_data;
            end
            if (c < len) @(negedge clk);
        end
        if (!chain) begin
            @(negedge clk);
            check("done_one_cycle", done_v[k], 1'b0);
            check("idle_line", tx_out_v[k], 1'b1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        reset   = 1'b0;
        start_v = '0;
        clr_cnt = 1'b0;
        for (int i = 0; i < 4; i++) data_v[i[1:0]] = 8'h00;

        // Reset state.
        repeat (3) @(negedge clk);
        check_int("rst_line", 32'(tx_out_v), 32'hF);
        check_int("rst_busy", 32'(busy_v), 32'h0);
        check_int("rst_strobes", 32'({wr_v, shift_v, step_v, done_v}), 32'h0);

        // Released, no requests: line idle, nothing asserted.
        reset = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            check_int("idle_line", 32'(tx_out_v), 32'hF);
            check_int("idle_busy", 32'(busy_v), 32'h0);
            check_int("idle_strobes", 32'({wr_v, shift_v, step_v, done_v}), 32'h0);
        end

        // 8N1, 0xA5: bits 1,0,1,0,0,1,0,1; done at cycle 40.
        start_frame(0, 8'hA5);
        watch_frame(0, 8'hA5, 8, 1'b0, 1'b0, 1, -1, 1'b0, 8'h00);
        check_int("a5_steps", step_cnt[0], 7);
        check_int("a5_writes", wr_cnt[0], 1);
        check_int("a5_dones", done_cnt[0], 1);

        // Even parity, 0x07 (three ones): parity bit 1, 44-cycle frame.
        start_frame(1, 8'h07);
        watch_frame(1, 8'h07, 8, 1'b1, 1'b1, 1, -1, 1'b0, 8'h00);
        check_int("even_steps", step_cnt[1], 7);

        // Odd parity, 0x07: parity bit 0.
        start_frame(2, 8'h07);
        watch_frame(2, 8'h07, 8, 1'b1, 1'b0, 1, -1, 1'b0, 8'h00);
        check_int("odd_dones", done_cnt[2], 1);

        // 7 data bits, 2 stops, 0x41: 40-cycle frame, 8 stop cycles, 6 steps.
        start_frame(3, 8'h41);
        watch_frame(3, 8'h41, 7, 1'b0, 1'b0, 2, -1, 1'b0, 8'h00);
        check_int("d7_steps", step_cnt[3], 6);
        check_int("d7_writes", wr_cnt[3], 1);

        // Mid-frame request with 0xFF ignored; request in done cycle chained.
        start_frame(0, 8'h3C);
        watch_frame(0, 8'h3C, 8, 1'b0, 1'b0, 1, 10, 1'b1, 8'hC3);
        @(negedge clk);
        start_v[0] = 1'b0;
        watch_frame(0, 8'hC3, 8, 1'b0, 1'b0, 1, -1, 1'b0, 8'h00);
        check_int("b2b_writes", wr_cnt[0], 2);
        check_int("b2b_steps", step_cnt[0], 14);
        check_int("b2b_dones", done_cnt[0], 2);

        // Reset during data bit 3 (0x5A bit3 = 1) aborts with no done.
        start_frame(0, 8'h5A);
        repeat (17) @(negedge clk);
        check("abort_pre_line", tx_out_v[0], 1'b1);
        check("abort_pre_busy", busy_v[0], 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check("abort_line", tx_out_v[0], 1'b1);
        check("abort_busy", busy_v[0], 1'b0);
        check("abort_shift", shift_v[0], 1'b0);
        check("abort_done", done_v[0], 1'b0);
        check("abort_step", step_v[0], 1'b0);
        reset = 1'b1;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            check("post_abort_done", done_v[0], 1'b0);
            check("post_abort_line", tx_out_v[0], 1'b1);
        end
        check_int("abort_no_done", done_cnt[0], 0);

        // Full frame after the abort.
        start_frame(0, 8'h5A);
        watch_frame(0, 8'h5A, 8, 1'b0, 1'b0, 1, -1, 1'b0, 8'h00);
        check_int("recover_steps", step_cnt[0], 7);
        check_int("recover_dones", done_cnt[0], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
